// File: rtl/pc_gen.sv
// pc_gen: prioritised next-PC selection for the fetch stage, holding under
// handshake/load-use/misalign stalls and capturing redirects seen while stalled.
module pc_gen #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(64'h8000_0000),
  parameter int FETCH_BYTES = 4,
  parameter int IALIGN_BITS = 2,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_ready,
  input  logic            load_stall,
  input  logic            csr_flush,
  input  logic [XLEN-1:0] csr_target,
  input  logic            jump_flag,
  input  logic [XLEN-1:0] jump_target,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_target,
  output logic [XLEN-1:0] pc,
  output logic            fetch_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic            redirect_pending,
  output logic            misalign
);
  localparam logic [1:0] CLS_NONE = 2'd0;
  localparam logic [1:0] CLS_JUMP = 2'd1;
  localparam logic [1:0] CLS_CSR  = 2'd2;
  logic [1:0]      r_pcls;
  logic [XLEN-1:0] r_ptgt;
  logic            w_hs;
  logic            w_hold;
  logic            w_capture;
  logic [1:0]      w_new_cls;
  logic [XLEN-1:0] w_new_tgt;
  logic [XLEN-1:0] w_pc_next;
  assign fetch_valid      = ~misalign;
  assign redirect_pending = (r_pcls != CLS_NONE);
  always_comb begin
    w_hs      = fetch_valid & ~fetch_ready;
    w_new_cls = csr_flush ? CLS_CSR : (jump_flag ? CLS_JUMP : CLS_NONE);
    w_new_tgt = csr_flush ? csr_target : jump_target;
    // a stored CSR redirect is never displaced by a later jump
    w_capture = w_hs & (w_new_cls != CLS_NONE) & (w_new_cls >= r_pcls);
    w_hold    = w_hs | ((w_new_cls == CLS_NONE) & (r_pcls == CLS_NONE) & (load_stall | misalign));
    w_pc_next = w_hold ? pc :
                (w_new_cls != CLS_NONE) ? w_new_tgt :
                (r_pcls != CLS_NONE) ? r_ptgt :
                pred_taken ? pred_target :
                pc + XLEN'(FETCH_BYTES);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_VEC;
      misalign  <= 1'b0;
      stall_cnt <= '0;
      r_pcls    <= CLS_NONE;
      r_ptgt    <= '0;
    end else begin
      pc        <= w_pc_next;
      misalign  <= |w_pc_next[IALIGN_BITS-1:0];
      stall_cnt <= w_hold ? stall_cnt + CNT_W'(!(&stall_cnt)) : '0;
      r_pcls    <= w_capture ? w_new_cls : (w_hs ? r_pcls : CLS_NONE);
      r_ptgt    <= w_capture ? w_new_tgt : r_ptgt;
    end
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vector table, hand corner sequences and randomized
// stimulus checked against a behavioural model of the next-PC rules.
module tb_pc_gen;
  localparam logic [63:0] B = 64'h8000_0000;
  logic clk = 1'b0;
  logic reset, fetch_ready, load_stall, csr_flush, jump_flag, pred_taken;
  logic [63:0] csr_target, jump_target, pred_target;
  logic [63:0] pc, s_pc;
  logic fetch_valid, redirect_pending, misalign, s_valid, s_pend, s_mis;
  logic [15:0] stall_cnt;
  logic [1:0] s_cnt;
  int checks = 0, failures = 0;
  logic [63:0] m_pc;
  logic m_mis, m_pv, m_pcsr;
  logic [63:0] m_ptgt;
  int m_cnt;

  always #5 clk = ~clk;

  pc_gen u_dut (
    .clk(clk), .reset(reset), .fetch_ready(fetch_ready), .load_stall(load_stall),
    .csr_flush(csr_flush), .csr_target(csr_target), .jump_flag(jump_flag),
    .jump_target(jump_target), .pred_taken(pred_taken), .pred_target(pred_target),
    .pc(pc), .fetch_valid(fetch_valid), .stall_cnt(stall_cnt),
    .redirect_pending(redirect_pending), .misalign(misalign)
  );

  pc_gen #(.CNT_W(2)) u_small (
    .clk(clk), .reset(reset), .fetch_ready(fetch_ready), .load_stall(load_stall),
    .csr_flush(csr_flush), .csr_target(csr_target), .jump_flag(jump_flag),
    .jump_target(jump_target), .pred_taken(pred_taken), .pred_target(pred_target),
    .pc(s_pc), .fetch_valid(s_valid), .stall_cnt(s_cnt),
    .redirect_pending(s_pend), .misalign(s_mis)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return v > mx ? mx : v;
  endfunction

  task automatic model_step(input logic rst, rdy, ls, cf, jf, pt,
                            input logic [63:0] ct, jt, ptg);
    logic held;
    logic [63:0] nxt;
    if (rst) begin
      m_pc = B; m_mis = 0; m_cnt = 0; m_pv = 0; m_pcsr = 0; m_ptgt = 0;
      return;
    end
    nxt = m_pc;
    if (!m_mis && !rdy) begin
      held = 1;
      if (cf) begin m_pv = 1; m_pcsr = 1; m_ptgt = ct; end
      else if (jf && !(m_pv && m_pcsr)) begin m_pv = 1; m_pcsr = 0; m_ptgt = jt; end
    end else begin
      held = 0;
      if (cf) nxt = ct;
      else if (jf) nxt = jt;
      else if (m_pv) nxt = m_ptgt;
      else if (ls || m_mis) held = 1;
      else if (pt) nxt = ptg;
      else nxt = m_pc + 64'd4;
      m_pv = 0;
    end
    m_pc  = nxt;
    m_cnt = held ? m_cnt + 1 : 0;
    m_mis = (m_pc[1:0] != 2'b00);
  endtask

  task automatic cyc(input logic rst, rdy, ls, cf, jf, pt, input logic [63:0] ct, jt, ptg);
    reset = rst; fetch_ready = rdy; load_stall = ls; csr_flush = cf; jump_flag = jf;
    pred_taken = pt; csr_target = ct; jump_target = jt; pred_target = ptg;
    @(posedge clk);
    model_step(rst, rdy, ls, cf, jf, pt, ct, jt, ptg);
    #1;
    chk("m_pc", pc, m_pc);
    chk("m_valid", 64'(fetch_valid), 64'(!m_mis));
    chk("m_mis", 64'(misalign), 64'(m_mis));
    chk("m_pend", 64'(redirect_pending), 64'(m_pv));
    chk("m_cnt", 64'(stall_cnt), 64'(sat(m_cnt, 65535)));
    chk("m_small_pc", s_pc, m_pc);
    chk("m_small_cnt", 64'(s_cnt), 64'(sat(m_cnt, 3)));
  endtask

  function automatic logic [63:0] rt();
    logic [63:0] t;
    t = {32'h0, 32'h8000_0000 | $urandom};
    if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  typedef struct {
    logic rdy, ls, cf, jf, pt;
    logic [63:0] ct, jt, ptg;
    logic [63:0] epc;
    logic ep, ev;
    int ecnt;
  } vec_t;

  vec_t v[19];

  initial begin
    v[0]  = '{1,0,0,0,0, 0, 0, 0, B+64'h4,   0,1,0};
    v[1]  = '{1,0,0,0,0, 0, 0, 0, B+64'h8,   0,1,0};
    v[2]  = '{1,0,0,0,0, 0, 0, 0, B+64'hC,   0,1,0};
    v[3]  = '{0,0,0,0,0, 0, 0, 0, B+64'hC,   0,1,1};
    v[4]  = '{0,0,0,1,0, 0, B+64'h100, 0, B+64'hC, 1,1,2};
    v[5]  = '{0,0,0,0,0, 0, 0, 0, B+64'hC,   1,1,3};
    v[6]  = '{0,0,0,0,0, 0, 0, 0, B+64'hC,   1,1,4};
    v[7]  = '{1,0,0,0,0, 0, 0, 0, B+64'h100, 0,1,0};
    v[8]  = '{0,0,1,0,0, B+64'h200, 0, 0, B+64'h100, 1,1,1};
    v[9]  = '{0,0,0,1,0, 0, B+64'h300, 0, B+64'h100, 1,1,2};
    v[10] = '{1,0,0,0,0, 0, 0, 0, B+64'h200, 0,1,0};
    v[11] = '{1,0,1,1,1, B+64'h400, B+64'h500, B+64'h600, B+64'h400, 0,1,0};
    v[12] = '{1,1,0,1,0, 0, B+64'h700, 0, B+64'h700, 0,1,0};
    v[13] = '{1,1,0,0,0, 0, 0, 0, B+64'h700, 0,1,1};
    v[14] = '{1,0,0,0,1, 0, 0, B+64'h800, B+64'h800, 0,1,0};
    v[15] = '{1,0,0,1,0, 0, B+64'h102, 0, B+64'h102, 0,0,0};
    v[16] = '{0,0,0,0,1, 0, 0, B+64'h900, B+64'h102, 0,0,1};
    v[17] = '{1,0,0,0,0, 0, 0, 0, B+64'h102, 0,0,2};
    v[18] = '{1,0,1,0,0, B+64'h1000, 0, 0, B+64'h1000, 0,1,0};

    cyc(1,1,0,0,0,0, 0,0,0);
    cyc(1,1,0,0,0,0, 0,0,0);
    chk("rst_pc", pc, B);
    chk("rst_cnt", 64'(stall_cnt), 0);
    chk("rst_pend", 64'(redirect_pending), 0);
    chk("rst_valid", 64'(fetch_valid), 1);
    chk("rst_mis", 64'(misalign), 0);

    foreach (v[i]) begin
      cyc(0, v[i].rdy, v[i].ls, v[i].cf, v[i].jf, v[i].pt, v[i].ct, v[i].jt, v[i].ptg);
      chk($sformatf("vec%0d_pc", i), pc, v[i].epc);
      chk($sformatf("vec%0d_pend", i), 64'(redirect_pending), 64'(v[i].ep));
      chk($sformatf("vec%0d_valid", i), 64'(fetch_valid), 64'(v[i].ev));
      chk($sformatf("vec%0d_cnt", i), 64'(stall_cnt), 64'(v[i].ecnt));
      chk($sformatf("vec%0d_scnt", i), 64'(s_cnt), 64'(v[i].ecnt > 3 ? 3 : v[i].ecnt));
    end

    cyc(0,1,0,0,1,0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    cyc(0,1,0,0,0,0, 0, 0, 0);
    chk("wrap_pc", pc, 64'h0);

    for (int k = 0; k < 6; k++) cyc(0,0,0,0,0,0, 0,0,0);
    chk("sat_small_cnt", 64'(s_cnt), 3);
    chk("sat_big_cnt", 64'(stall_cnt), 6);

    cyc(0,0,0,0,1,0, 0, B+64'h40, 0);
    chk("pre_rst_pend", 64'(redirect_pending), 1);
    cyc(1,0,0,1,0,0, B+64'h80, 0, 0);
    chk("midrst_pc", pc, B);
    chk("midrst_pend", 64'(redirect_pending), 0);
    chk("midrst_cnt", 64'(stall_cnt), 0);
    cyc(0,1,0,0,0,0, 0,0,0);
    chk("post_rst_pc", pc, B + 64'h4);

    cyc(0,0,1,0,0,0, B+64'h20, 0, 0);
    cyc(0,1,0,0,1,0, 0, B+64'h30, 0);
    chk("release_new_wins", pc, B + 64'h30);
    chk("release_pend_clr", 64'(redirect_pending), 0);

    for (int k = 0; k < 600; k++)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
          $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 3,
          rt(), rt(), rt());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised PC generation stage at the head of the fetch pipeline; successor to the single-source PC register.
- Selects the next PC by priority from three sources:
  - CSR/trap flush
  - resolved branch/jump
  - front-end prediction
  - otherwise sequential increment.
- Holds PC stable under a valid/ready fetch handshake and under load-use stalls.
- Captures redirects that arrive while the handshake is stalled, so none are lost.
- Exposes a saturating stall counter and a misalignment flag.

Parameters:
- XLEN, 64, PC and target width.
- RESET_VEC, 64'h8000_0000, PC value loaded by reset.
- FETCH_BYTES, 4, sequential increment per accepted fetch; power of two, at least 2.
- IALIGN_BITS, 2, number of PC LSBs that must be zero for a legal fetch address.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- fetch_ready  in  1  instruction memory accepts the request this cycle.
- load_stall  in  1  decode/execute load-use stall; hold PC.
- csr_flush  in  1  trap/CSR redirect request.
- csr_target  in  XLEN  target for csr_flush.
- jump_flag  in  1  resolved branch/jump redirect request.
- jump_target  in  XLEN  target for jump_flag.
- pred_taken  in  1  predictor redirect for the current fetch.
- pred_target  in  XLEN  target for pred_taken.
- pc  out  XLEN  current fetch address.
- fetch_valid  out  1  fetch request valid.
- stall_cnt  out  CNT_W  consecutive held cycles.
- redirect_pending  out  1  a captured redirect is waiting.
- misalign  out  1  pc violates IALIGN_BITS.

Behaviour:
- One clock, clk; reset is synchronous and active-high.
- Reset values: pc=RESET_VEC, stall_cnt=0, redirect_pending=0, pending class/target cleared, misalign=0.
- fetch_valid is combinational: high whenever misalign=0. On the first cycle after reset it is 1.
- Handshake stall, hs = fetch_valid & ~fetch_ready:
  - pc, misalign and fetch_valid stay stable until fetch_ready=1.
  - Any csr_flush or jump_flag arriving during hs is captured into the pending register. redirect_pending=1 from the next cycle.
  - Pending class priority: CSR (2) > JUMP (1).
  - A new redirect overwrites the pending one only if its class >= the stored class. A jump never replaces a pending CSR.
  - pred_taken is ignored during hs.
- Next-PC selection when not in hs, highest first:
  1. csr_flush: pc <= csr_target.
  2. jump_flag: pc <= jump_target.
  3. redirect_pending: pc <= pending target, then clear pending.
  4. load_stall: pc holds.
  5. pred_taken: pc <= pred_target.
  6. Sequential: pc <= pc + FETCH_BYTES, modulo 2^XLEN; wraps silently at all-ones.
- A new csr/jump arriving on the release cycle wins over pending, and pending is cleared.
- Redirects 1–2 apply even under load_stall.
- misalign=1 state:
  - misalign is registered with pc: 1 iff the new pc has any of bits [IALIGN_BITS-1:0] set.
  - While misalign=1, fetch_valid=0, so there is no hs.
  - PC holds until csr_flush or jump_flag; sequential and pred updates are suppressed.
- stall_cnt:
  - Increments on every cycle pc holds (hs, load_stall, or misalign hold).
  - Saturates at all-ones.
  - Cleared to 0 on any cycle pc is updated.
- Reset asserted mid-operation overrides everything in that cycle, including a pending redirect.

Test Plan:
- Reset, then fetch_ready=1 for 3 cycles, no other inputs -> pc = 8000_0000, 8000_0004, 8000_0008, 8000_000C; stall_cnt=0; fetch_valid=1.
- fetch_ready=0 for 4 cycles; jump_flag=1 with target 8000_0100 in cycle 2 -> pc stable; redirect_pending=1; stall_cnt=1..4; on release pc=8000_0100 and pending=0.
- During hs: csr_flush with target 8000_0200, then jump_flag with target 8000_0300 -> release gives pc=8000_0200 (jump discarded).
- csr_flush and jump_flag and pred_taken asserted in the same cycle, no hs -> pc=csr_target; load_stall=1 with jump_flag -> pc=jump_target.
- jump_target=8000_0102 -> misalign=1, fetch_valid=0, pc held, stall_cnt counting; csr_flush with target 8000_1000 -> misalign=0, fetch_valid=1.
- CNT_W=2, hold 6 cycles -> stall_cnt saturates at 3; assert reset during hs with pending set -> pc=RESET_VEC, pending=0, stall_cnt=0.
